// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory boot loader.
package pm_loader_pkg;

  localparam int          WORD_W    = 24;
  localparam int          ADDR_W    = 8;
  localparam logic [7:0]  HEADER    = 8'hA5;
  localparam logic [7:0]  BASE_ADDR = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COUNT,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the loader takes a byte from the host link.
  function automatic logic accepts_byte(input state_t s);
    return (s inside {ST_IDLE, ST_COUNT, ST_B2, ST_B1, ST_B0, ST_CHK});
  endfunction

endpackage

// File: rtl/pm_word_assembler.sv
// Byte-lane shift register building a big-endian word, plus the running checksum.
// The checksum accumulator exists only when PM_LOADER_CHECKSUM_EN is defined.
module pm_word_assembler
  import pm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [7:0]        i_byte,
`ifdef PM_LOADER_CHECKSUM_EN
  output logic [7:0]        o_sum_next,
`endif
  output logic [WORD_W-1:0] o_word_next
);

  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;

  assign w_word_next = {r_word[WORD_W-9:0], i_byte};
  assign o_word_next = w_word_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
    end else if (i_shift) begin
      r_word <= w_word_next;
    end
  end

`ifdef PM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;

  // Sum including the byte currently on the link; used for both shift and the final check.
  assign w_sum_next = r_sum + i_byte;
  assign o_sum_next = w_sum_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_shift) begin
      r_sum <= w_sum_next;
    end
  end
`endif

endmodule

// File: rtl/pm_loader.sv
// Boot-time loader: framed host bytes -> 24-bit program-memory writes, then core release.
// Optional trailing checksum byte enabled by defining PM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | hunting for HEADER, other bytes dropped
// COUNT    | waiting for word count (0 means 256)
// B2/B1/B0 | collecting word bytes MSB first
// WRITE    | one-cycle program-memory write
// CHK      | waiting for checksum byte
// DONE     | image loaded, core released
// ERR      | checksum failed, core held
module pm_loader
  import pm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_din,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

  state_t              r_state;
  state_t              w_next;
  logic                r_rx_ready;
  logic                r_pm_we;
  logic [ADDR_W-1:0]   r_pm_addr;
  logic [WORD_W-1:0]   r_pm_din;
  logic                r_cpu_run;
  logic                r_load_done;
  logic [8:0]          r_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                w_accept;
  logic                w_clr;
  logic                w_shift;
  logic [WORD_W-1:0]   w_word_next;
`ifdef PM_LOADER_CHECKSUM_EN
  logic [7:0]          w_sum_next;
  logic                r_load_err;
`endif

  assign w_accept = rx_valid && r_rx_ready;

  pm_word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_byte      (rx_data),
`ifdef PM_LOADER_CHECKSUM_EN
    .o_sum_next  (w_sum_next),
`endif
    .o_word_next (w_word_next)
  );

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && rx_data == HEADER) w_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_accept) begin
          w_clr  = 1'b1;
          w_next = ST_B2;
        end
      end
      ST_B2: begin
        if (w_accept) begin
          w_shift = 1'b1;
          w_next  = ST_B1;
        end
      end
      ST_B1: begin
        if (w_accept) begin
          w_shift = 1'b1;
          w_next  = ST_B0;
        end
      end
      ST_B0: begin
        if (w_accept) begin
          w_shift = 1'b1;
          w_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_cnt == 9'd1) begin
`ifdef PM_LOADER_CHECKSUM_EN
          w_next = ST_CHK;
`else
          w_next = ST_DONE;
`endif
        end else begin
          w_next = ST_B2;
        end
      end
`ifdef PM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_accept) w_next = (w_sum_next == 8'h00) ? ST_DONE : ST_ERR;
      end
      ST_ERR: begin
        if (load_req) w_next = ST_IDLE;
      end
`endif
      ST_DONE: begin
        if (load_req) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // All outputs are registered decodes of the next state, so nothing combinational reaches a port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rx_ready  <= 1'b1;
      r_pm_we     <= 1'b0;
      r_pm_addr   <= BASE_ADDR;
      r_pm_din    <= '0;
      r_cpu_run   <= 1'b0;
      r_load_done <= 1'b0;
      r_cnt       <= 9'd0;
      r_ptr       <= BASE_ADDR;
    end else begin
      r_state     <= w_next;
      r_rx_ready  <= accepts_byte(w_next);
      r_pm_we     <= (w_next == ST_WRITE);
      r_cpu_run   <= (w_next == ST_DONE);
      r_load_done <= (w_next == ST_DONE);
      if (w_next == ST_WRITE) begin
        r_pm_addr <= r_ptr;
        r_pm_din  <= w_word_next;
      end
      if (w_clr) begin
        r_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        r_ptr <= BASE_ADDR;
      end else if (r_state == ST_WRITE) begin
        r_cnt <= r_cnt - 9'd1;
        r_ptr <= r_ptr + 8'd1;
      end
    end
  end

`ifdef PM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_load_err <= 1'b0;
    else        r_load_err <= (w_next == ST_ERR);
  end
  assign load_err = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  assign rx_ready  = r_rx_ready;
  assign pm_we     = r_pm_we;
  assign pm_addr   = r_pm_addr;
  assign pm_din    = r_pm_din;
  assign cpu_run   = r_cpu_run;
  assign load_done = r_load_done;

endmodule
